// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router: header-marked byte FIFO with
// read-side packet-end tracking and a self-flush when the destination stalls.
module router_out_fifo #(
    parameter int DEPTH   = 16,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 30
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_reset,
    output logic             pkt_end
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LEN_W = WIDTH - 2;
    localparam int CNT_W = LEN_W + 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [AW:0]       PTR_ONE = (AW + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [TO_W-1:0]   TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

    logic [WIDTH:0]     r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic [CNT_W-1:0]   r_pkt_cnt;
    logic [TO_W-1:0]    r_to_cnt;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_soft_reset;
    logic               r_pkt_end;

    logic               w_empty;
    logic               w_full;
    logic               w_do_wr;
    logic               w_do_rd;
    logic               w_to_hold;
    logic               w_flush;
    logic [WIDTH:0]     w_rd_entry;
    logic [CNT_W-1:0]   w_hdr_load;

    // Extra pointer MSB separates the full case from the empty case.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                        (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_wr    = write_enb && !w_full;
    assign w_do_rd    = read_enb && !w_empty;
    assign w_to_hold  = !w_empty && !read_enb;
    assign w_flush    = w_to_hold && (r_to_cnt == TO_LAST);
    assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

    // Header bits [WIDTH-1:2] carry payload length; +1 accounts for the parity byte.
    assign w_hdr_load = {1'b0, w_rd_entry[WIDTH-1:2]} + CNT_ONE;

    always_ff @(posedge clock) begin
        if (w_do_wr && !w_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_pkt_cnt    <= '0;
            r_to_cnt     <= '0;
            r_data_out   <= '0;
            r_soft_reset <= 1'b0;
            r_pkt_end    <= 1'b0;
        end else begin
            r_soft_reset <= 1'b0;
            r_pkt_end    <= 1'b0;
            if (w_flush) begin
                // Stalled destination: drop everything, including any write on this edge.
                r_wr_ptr     <= '0;
                r_rd_ptr     <= '0;
                r_pkt_cnt    <= '0;
                r_to_cnt     <= '0;
                r_soft_reset <= 1'b1;
            end else begin
                if (w_do_wr) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_do_rd) begin
                    r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                    r_data_out <= w_rd_entry[WIDTH-1:0];
                    if (w_rd_entry[WIDTH]) begin
                        r_pkt_cnt <= w_hdr_load;
                    end else if (r_pkt_cnt != '0) begin
                        r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
                        r_pkt_end <= (r_pkt_cnt == CNT_ONE);
                    end
                end
                r_to_cnt <= w_to_hold ? (r_to_cnt + TO_ONE) : '0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign vld_out    = !w_empty;
    assign full       = w_full;
    assign empty      = w_empty;
    assign soft_reset = r_soft_reset;
    assign pkt_end    = r_pkt_end;

endmodule

// File: tb/tb_router_out_fifo.sv
// Bench for router_out_fifo: directed table, hand-written corner sequences and
// random traffic, all checked against a queue-based reference model.
module tb_router_out_fifo;

    localparam int DEPTH   = 16;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 30;

    logic             clock;
    logic             reset;
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             vld_out;
    logic             full;
    logic             empty;
    logic             soft_reset;
    logic             pkt_end;

    router_out_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .reset      (reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset),
        .pkt_end    (pkt_end)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain queue of {marker, byte} plus counters of remaining
    // packet bytes and consecutive unread cycles.
    logic [WIDTH:0]   mq[$];
    logic [WIDTH-1:0] m_data = '0;
    logic             m_soft = 1'b0;
    logic             m_pend = 1'b0;
    int               m_pkt  = 0;
    int               m_idle = 0;

    typedef struct {
        logic       rst;
        logic       we;
        logic       lfd;
        logic [7:0] din;
        logic       re;
        logic [7:0] e_do;
        logic       e_vld;
        logic       e_full;
        logic       e_empty;
        logic       e_pend;
        logic       e_soft;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic we, input logic lfd,
                              input logic [7:0] din, input logic re);
        logic [WIDTH:0] e;
        bit was_valid;
        bit was_full;
        bit flushed;
        if (rst) begin
            mq.delete();
            m_data = '0;
            m_soft = 1'b0;
            m_pend = 1'b0;
            m_pkt  = 0;
            m_idle = 0;
        end else begin
            m_soft    = 1'b0;
            m_pend    = 1'b0;
            was_valid = (mq.size() != 0);
            was_full  = (mq.size() == DEPTH);
            flushed   = 0;
            if (was_valid && !re) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    flushed = 1;
                    mq.delete();
                    m_pkt  = 0;
                    m_idle = 0;
                    m_soft = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
            if (!flushed) begin
                if (re && was_valid) begin
                    e = mq.pop_front();
                    m_data = e[WIDTH-1:0];
                    if (e[WIDTH]) begin
                        m_pkt = int'(e[WIDTH-1:2]) + 1;
                    end else if (m_pkt > 0) begin
                        m_pkt--;
                        if (m_pkt == 0) m_pend = 1'b1;
                    end
                end
                if (we && !was_full) mq.push_back({lfd, din});
            end
        end
    endtask

    // One clock: drive inputs, advance model and DUT, compare every output.
    task automatic step(input logic rst, input logic we, input logic lfd,
                        input logic [7:0] din, input logic re);
        reset     = rst;
        write_enb = we;
        lfd_state = lfd;
        data_in   = din;
        read_enb  = re;
        model_edge(rst, we, lfd, din, re);
        @(posedge clock);
        #1;
        chk("data_out",   32'(data_out),   32'(m_data));
        chk("vld_out",    32'(vld_out),    32'(mq.size() != 0));
        chk("empty",      32'(empty),      32'(mq.size() == 0));
        chk("full",       32'(full),       32'(mq.size() == DEPTH));
        chk("soft_reset", 32'(soft_reset), 32'(m_soft));
        chk("pkt_end",    32'(pkt_end),    32'(m_pend));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    int    pct_re;
    logic  rw, rr, rl, rs;
    logic [7:0] rd;

    initial begin
        reset = 1'b0; write_enb = 1'b0; lfd_state = 1'b0; data_in = '0; read_enb = 1'b0;

        //          rst we  lfd din    re   do     vld full emp pend soft
        tbl[0]  = '{1'b1,1'b1,1'b0,8'hAA,1'b0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,8'hAB,1'b0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,8'h00,1'b0, 8'h00,1'b0,1'b0,1'b1,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b1,8'h0D,1'b0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b1,1'b0,8'hA1,1'b0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,8'hA2,1'b0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b0,8'hA3,1'b0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,8'h5E,1'b0, 8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'h0D,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'hA1,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'hA2,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'hA3,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'h5E,1'b0,1'b0,1'b1,1'b1,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 8'h5E,1'b0,1'b0,1'b1,1'b0,1'b0};

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re);
            chk("tbl_data",  32'(data_out),   32'(tbl[i].e_do));
            chk("tbl_vld",   32'(vld_out),    32'(tbl[i].e_vld));
            chk("tbl_full",  32'(full),       32'(tbl[i].e_full));
            chk("tbl_empty", 32'(empty),      32'(tbl[i].e_empty));
            chk("tbl_pend",  32'(pkt_end),    32'(tbl[i].e_pend));
            chk("tbl_soft",  32'(soft_reset), 32'(tbl[i].e_soft));
        end

        // Full / overflow: 17 writes, the last dropped.
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i), 1'b0);
            chk("ovf_full", 32'(full), 32'(i >= 15));
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("ovf_data", 32'(data_out), 32'(i));
        end
        chk("ovf_empty", 32'(empty), 32'd1);

        // Full with simultaneous read and write: write must be dropped.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hEE, 1'b1);
        chk("fullrw_data", 32'(data_out), 32'h80);
        chk("fullrw_full", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("fullrw_drain", 32'(data_out), 32'(8'h80 + i));
        end
        chk("fullrw_empty", 32'(empty), 32'd1);

        // Wrap with concurrent traffic at constant occupancy 8.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, 1'b0, 8'(8'h48 + k), 1'b1);
            chk("wrap_data", 32'(data_out), 32'(8'h40 + k));
            chk("wrap_flags", 32'({full, empty}), 32'd0);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("wrap_drain", 32'(data_out), 32'(8'h68 + k));
        end

        // Timeout: one byte left unread.
        step(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        for (int k = 1; k <= TIMEOUT + 1; k++) begin
            idle();
            chk("to_pulse", 32'(soft_reset), 32'(k == TIMEOUT));
            chk("to_vld",   32'(vld_out),    32'(k < TIMEOUT));
        end

        // Timeout interrupted by a read on cycle 29; count restarts.
        step(1'b0, 1'b1, 1'b0, 8'h31, 1'b0);
        for (int k = 1; k <= TIMEOUT - 2; k++) idle();
        step(1'b0, 1'b1, 1'b0, 8'h32, 1'b1);
        chk("to2_nopulse", 32'(soft_reset), 32'd0);
        chk("to2_data",    32'(data_out),   32'h31);
        for (int k = 1; k <= TIMEOUT; k++) begin
            idle();
            chk("to2_pulse", 32'(soft_reset), 32'(k == TIMEOUT));
        end

        // Truncated packet: header 14 (len 5) cut short by header 08 (len 2).
        step(1'b0, 1'b1, 1'b1, 8'h14, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hB1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hB2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h08, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hC1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hC2, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hC3, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            chk("trunc_pend", 32'(pkt_end), 32'(k == 6));
        end

        // Random traffic; read pressure varies per phase so timeouts also occur.
        for (int ph = 0; ph < 12; ph++) begin
            pct_re = (ph % 4 == 3) ? 2 : int'($urandom_range(10, 90));
            for (int c = 0; c < 200; c++) begin
                rs = ($urandom_range(0, 299) == 0);
                rw = ($urandom_range(0, 99) < 55);
                rl = ($urandom_range(0, 5) == 0);
                rr = (int'($urandom_range(0, 99)) < pct_re);
                rd = 8'($urandom);
                step(rs, rw, rl, rd, rr);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
